// File: rtl/vga_text_renderer_if.sv
// -----------------------------------------------------------------------------
// vga_text_renderer_if
//   Read-port bundle between the text renderer and the character/colour map
//   and glyph memories held by the parent. Both memories answer with a fixed
//   one-cycle read latency.
//
//   Signals:
//     map_addr   char/colour map read address (renderer -> memory)
//     map_code   glyph code, valid 1 cycle after map_addr
//     map_attr   [7:4] fg index, [3:0] bg index, valid 1 cycle after map_addr
//     glyph_addr {code, glyph line} (renderer -> memory)
//     glyph_row  glyph line bits, valid 1 cycle after glyph_addr;
//                bit x = pixel column x
//
//   Modports: master = renderer side, slave = memory side.
// -----------------------------------------------------------------------------
interface vga_text_renderer_if #(
  parameter int MAP_AW   = 12,
  parameter int CODE_W   = 8,
  parameter int GLYPH_AW = 12,
  parameter int GLYPH_W  = 8
);
  logic [MAP_AW-1:0]   map_addr;
  logic [CODE_W-1:0]   map_code;
  logic [7:0]          map_attr;
  logic [GLYPH_AW-1:0] glyph_addr;
  logic [GLYPH_W-1:0]  glyph_row;

  modport master (
    output map_addr, glyph_addr,
    input  map_code, map_attr, glyph_row
  );

  modport slave (
    input  map_addr, glyph_addr,
    output map_code, map_attr, glyph_row
  );
endinterface

// File: rtl/vga_text_renderer.sv
// -----------------------------------------------------------------------------
// vga_text_renderer
//   Parametrised text-mode VGA pixel engine. Generates video timing from a
//   pixel tick (one factor_clk_i cycle in CLK_DIV), fetches character code and
//   attribute from the map, then the glyph line, and drives palette colour.
//   Supports hardware vertical scroll with row wrap-around. The blinking
//   block cursor is built only when VGACHARGEN_CURSOR_EN is defined;
//   otherwise the cursor inputs are ignored.
//
//   Ports:
//     factor_clk_i    pixel-domain clock
//     factor_arstn_i  asynchronous active-low reset
//     scroll_row_i    map row shown at screen row 0 (taken at frame start)
//     cursor_en_i     cursor enable
//     cursor_col_i    cursor cell column, screen coordinates
//     cursor_row_i    cursor cell row, screen coordinates
//     mem             map/glyph read ports (vga_text_renderer_if.master)
//     vga_r/g/b_o     colour, COLOR_W bits per channel
//     vga_hs_o/vs_o   syncs, active-low
//     frame_start_o   one-cycle pulse with pixel (0,0)
//
//   Colour, syncs and frame_start_o all lag the counters by exactly three
//   factor_clk_i cycles, so they stay aligned for any CLK_DIV.
//   GLYPH_W and GLYPH_H must be at least 2.
// -----------------------------------------------------------------------------
package vga_text_renderer_pkg;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;

  // Classic 16-colour text palette.
  function automatic rgb4_t color_decode(input logic [3:0] idx);
    case (idx)
      4'd0:    return '{4'h0, 4'h0, 4'h0};
      4'd1:    return '{4'h0, 4'h0, 4'hA};
      4'd2:    return '{4'h0, 4'hA, 4'h0};
      4'd3:    return '{4'h0, 4'hA, 4'hA};
      4'd4:    return '{4'hA, 4'h0, 4'h0};
      4'd5:    return '{4'hA, 4'h0, 4'hA};
      4'd6:    return '{4'hA, 4'h5, 4'h0};
      4'd7:    return '{4'hA, 4'hA, 4'hA};
      4'd8:    return '{4'h5, 4'h5, 4'h5};
      4'd9:    return '{4'h5, 4'h5, 4'hF};
      4'd10:   return '{4'h5, 4'hF, 4'h5};
      4'd11:   return '{4'h5, 4'hF, 4'hF};
      4'd12:   return '{4'hF, 4'h5, 4'h5};
      4'd13:   return '{4'hF, 4'h5, 4'hF};
      4'd14:   return '{4'hF, 4'hF, 4'h5};
      default: return '{4'hF, 4'hF, 4'hF};
    endcase
  endfunction
endpackage

module vga_text_renderer
  import vga_text_renderer_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int GLYPH_W      = 8,
  parameter int GLYPH_H      = 16,
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CODE_W       = 8,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                      factor_clk_i,
  input  logic                      factor_arstn_i,
  input  logic [$clog2(ROWS)-1:0]   scroll_row_i,
  input  logic                      cursor_en_i,
  input  logic [$clog2(COLS)-1:0]   cursor_col_i,
  input  logic [$clog2(ROWS)-1:0]   cursor_row_i,
  vga_text_renderer_if.master       mem,
  output logic [COLOR_W-1:0]        vga_r_o,
  output logic [COLOR_W-1:0]        vga_g_o,
  output logic [COLOR_W-1:0]        vga_b_o,
  output logic                      vga_hs_o,
  output logic                      vga_vs_o,
  output logic                      frame_start_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PXW     = $clog2(GLYPH_W);
  localparam int LNW     = $clog2(GLYPH_H);
  localparam int CW      = $clog2(H_TOTAL / GLYPH_W + 2);
  localparam int SW      = $clog2(V_TOTAL / GLYPH_H + 2);
  localparam int ROW_RW  = $clog2(ROWS);
  localparam int MAP_AW  = $clog2(COLS * ROWS);

  // ---------------------------------------------------------------------------
  // Pixel tick and raster counters. Cell/offset counters run alongside
  // hcount/vcount so no divider is needed.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]  div_q;
  logic [HW-1:0]  hcount_q;
  logic [VW-1:0]  vcount_q;
  logic [PXW-1:0] px_q;
  logic [CW-1:0]  col_q;
  logic [LNW-1:0] line_q;
  logic [SW-1:0]  srow_q;

  // A pixel lasts CLK_DIV cycles: its first cycle carries frame-start events,
  // its last cycle advances the counters.
  wire pix_first  = (div_q == '0);
  wire pix_last   = (div_q == DW'(CLK_DIV - 1));
  wire h_wrap     = (hcount_q == HW'(H_TOTAL - 1));
  wire v_wrap     = (vcount_q == VW'(V_TOTAL - 1));
  wire frame_tick = pix_first && (hcount_q == '0) && (vcount_q == '0);

  // NOTE: state updates use non-blocking assignments and the reset is in the
  // sensitivity list, so reset takes effect immediately, not on the next edge.
  always_ff @(posedge factor_clk_i or negedge factor_arstn_i) begin
    if (!factor_arstn_i) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      px_q     <= '0;
      col_q    <= '0;
      line_q   <= '0;
      srow_q   <= '0;
    end else begin
      div_q <= pix_last ? '0 : div_q + 1'b1;
      if (pix_last) begin
        if (h_wrap) begin
          hcount_q <= '0;
          px_q     <= '0;
          col_q    <= '0;
          if (v_wrap) begin
            vcount_q <= '0;
            line_q   <= '0;
            srow_q   <= '0;
          end else begin
            vcount_q <= vcount_q + 1'b1;
            if (line_q == LNW'(GLYPH_H - 1)) begin
              line_q <= '0;
              srow_q <= srow_q + 1'b1;
            end else begin
              line_q <= line_q + 1'b1;
            end
          end
        end else begin
          hcount_q <= hcount_q + 1'b1;
          if (px_q == PXW'(GLYPH_W - 1)) begin
            px_q  <= '0;
            col_q <= col_q + 1'b1;
          end else begin
            px_q <= px_q + 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scroll: out-of-range requests collapse to 0. On the frame-start cycle the
  // freshly sampled value is used directly so the whole of pixel (0,0)
  // already sees the new offset.
  // ---------------------------------------------------------------------------
  logic [ROW_RW-1:0] scroll_q;
  logic [ROW_RW-1:0] scroll_in;
  logic [ROW_RW-1:0] scroll_eff;
  logic [SW:0]       row_sum;
  logic [SW:0]       map_row;

  assign scroll_in = (32'(scroll_row_i) >= ROWS) ? '0 : scroll_row_i;

  // NOTE: frame_tick is true while reset is held (counters are 0), so the
  // combinational read addresses are gated by the reset pin to hold them at 0.
  assign scroll_eff = (frame_tick && factor_arstn_i) ? scroll_in : scroll_q;
  assign row_sum    = {1'b0, srow_q} + (SW + 1)'(scroll_eff);
  assign map_row    = (row_sum >= (SW + 1)'(ROWS)) ? row_sum - (SW + 1)'(ROWS) : row_sum;

  assign mem.map_addr = MAP_AW'(map_row) * MAP_AW'(COLS) + MAP_AW'(col_q);

  always_ff @(posedge factor_clk_i or negedge factor_arstn_i) begin
    if (!factor_arstn_i)  scroll_q <= '0;
    else if (frame_tick)  scroll_q <= scroll_in;
  end

  // ---------------------------------------------------------------------------
  // Cursor and blink. The first frame after reset counts as frame 0, so with
  // BLINK_FRAMES=N the cursor shows during frames N..2N-1, 3N..4N-1, ...
  // ---------------------------------------------------------------------------
  logic cursor_hit;
`ifdef VGACHARGEN_CURSOR_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  wire blink_toggle = frame_tick && (blink_cnt_q == BW'(BLINK_FRAMES));
  wire blink_eff    = blink_q ^ blink_toggle;

  assign cursor_hit = cursor_en_i && blink_eff
                   && (32'(cursor_col_i) < COLS) && (32'(cursor_row_i) < ROWS)
                   && (32'(col_q) == 32'(cursor_col_i))
                   && (32'(srow_q) == 32'(cursor_row_i));

  always_ff @(posedge factor_clk_i or negedge factor_arstn_i) begin
    if (!factor_arstn_i) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (frame_tick) begin
      if (blink_toggle) begin
        blink_cnt_q <= BW'(1);
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end
`else
  assign cursor_hit = 1'b0;
  wire unused_cursor = ^{cursor_en_i, cursor_col_i, cursor_row_i};
  localparam int unused_blink_frames = BLINK_FRAMES;
`endif

  // ---------------------------------------------------------------------------
  // Pipeline: stage 1 waits for the map read, stage 2 for the glyph read.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [PXW-1:0] px;
    logic           active;
    logic           text;
    logic           hs;
    logic           vs;
    logic           fs;
    logic           hit;
  } ctl_t;

  localparam ctl_t CTL_RST = '{px: '0, active: 1'b0, text: 1'b0, hs: 1'b1,
                               vs: 1'b1, fs: 1'b0, hit: 1'b0};

  ctl_t           ctl0, ctl1_q, ctl2_q;
  logic [LNW-1:0] line1_q;
  logic [7:0]     attr2_q;

  assign ctl0.px     = px_q;
  assign ctl0.active = (32'(hcount_q) < H_ACTIVE) && (32'(vcount_q) < V_ACTIVE);
  assign ctl0.text   = (32'(hcount_q) < COLS * GLYPH_W) && (32'(vcount_q) < ROWS * GLYPH_H);
  assign ctl0.hs     = !((32'(hcount_q) >= H_ACTIVE + H_FP) &&
                         (32'(hcount_q) <  H_ACTIVE + H_FP + H_SYNC));
  assign ctl0.vs     = !((32'(vcount_q) >= V_ACTIVE + V_FP) &&
                         (32'(vcount_q) <  V_ACTIVE + V_FP + V_SYNC));
  assign ctl0.fs     = frame_tick;
  assign ctl0.hit    = cursor_hit;

  assign mem.glyph_addr = factor_arstn_i ? {mem.map_code, line1_q} : '0;

  always_ff @(posedge factor_clk_i or negedge factor_arstn_i) begin
    if (!factor_arstn_i) begin
      ctl1_q  <= CTL_RST;
      ctl2_q  <= CTL_RST;
      line1_q <= '0;
      attr2_q <= '0;
    end else begin
      ctl1_q  <= ctl0;
      line1_q <= line_q;
      ctl2_q  <= ctl1_q;
      attr2_q <= mem.map_attr;
    end
  end

  // ---------------------------------------------------------------------------
  // Colour select and channel width adaptation.
  // ---------------------------------------------------------------------------
  // Left-replicate the 4-bit channel; for COLOR_W<4 this keeps the MSBs.
  function automatic logic [COLOR_W-1:0] widen(input logic [3:0] c);
    logic [COLOR_W-1:0] w;
    for (int k = 0; k < COLOR_W; k++) w[COLOR_W-1-k] = c[3-(k%4)];
    return w;
  endfunction

  logic [3:0] fg_idx, bg_idx;
  rgb4_t      pix_rgb;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fg_idx  = attr2_q[7:4];
    bg_idx  = attr2_q[3:0];
    if (ctl2_q.hit) begin
      fg_idx = attr2_q[3:0];
      bg_idx = attr2_q[7:4];
    end
    pix_rgb = color_decode(mem.glyph_row[ctl2_q.px] ? fg_idx : bg_idx);
    if (!(ctl2_q.active && ctl2_q.text)) pix_rgb = '0;
  end

  always_ff @(posedge factor_clk_i or negedge factor_arstn_i) begin
    if (!factor_arstn_i) begin
      vga_r_o       <= '0;
      vga_g_o       <= '0;
      vga_b_o       <= '0;
      vga_hs_o      <= 1'b1;
      vga_vs_o      <= 1'b1;
      frame_start_o <= 1'b0;
    end else begin
      vga_r_o       <= widen(pix_rgb.r);
      vga_g_o       <= widen(pix_rgb.g);
      vga_b_o       <= widen(pix_rgb.b);
      vga_hs_o      <= ctl2_q.hs;
      vga_vs_o      <= ctl2_q.vs;
      frame_start_o <= ctl2_q.fs;
    end
  end
endmodule

// File: tb/tb_vga_text_renderer.sv
// -----------------------------------------------------------------------------
// tb_vga_text_renderer
//   Small-geometry bench for vga_text_renderer: CLK_DIV=2, 5x3 text grid of
//   8x4 glyphs inside a 48x16 active area (so columns 40..47 are active but
//   outside the text). A behavioural raster model predicts every output cycle;
//   predictions are queued when the counters reach a pixel and popped when
//   the delayed output appears. Covers scroll wrap, mid-frame scroll change,
//   cursor blink / out-of-range cursor (when VGACHARGEN_CURSOR_EN is defined)
//   and reset asserted mid-frame.
// -----------------------------------------------------------------------------
module tb_vga_text_renderer;
  localparam int CLK_DIV = 2;
  localparam int H_ACTIVE = 48, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_ACTIVE = 16, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int GLYPH_W = 8, GLYPH_H = 4, COLS = 5, ROWS = 3;
  localparam int CODE_W = 8, COLOR_W = 4, BLINK_FRAMES = 2;
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CYC = H_TOT * V_TOT * CLK_DIV;
  localparam int LINE_CYC = H_TOT * CLK_DIV;
  localparam int MAP_AW = $clog2(COLS * ROWS);
  localparam int GLYPH_AW = CODE_W + $clog2(GLYPH_H);
  localparam logic [14:0] RST_VEC = {1'b0, 1'b1, 1'b1, 12'h000};
`ifdef VGACHARGEN_CURSOR_EN
  localparam bit CURSOR_ON = 1'b1;
`else
  localparam bit CURSOR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [$clog2(ROWS)-1:0] scroll_row = '0;
  logic cursor_en = 1'b0;
  logic [$clog2(COLS)-1:0] cursor_col = '0;
  logic [$clog2(ROWS)-1:0] cursor_row = '0;
  logic [COLOR_W-1:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, frame_start;

  vga_text_renderer_if #(.MAP_AW(MAP_AW), .CODE_W(CODE_W),
                         .GLYPH_AW(GLYPH_AW), .GLYPH_W(GLYPH_W)) bus ();

  vga_text_renderer #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .COLS(COLS), .ROWS(ROWS),
    .CODE_W(CODE_W), .COLOR_W(COLOR_W), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .factor_clk_i  (clk),
    .factor_arstn_i(rst_n),
    .scroll_row_i  (scroll_row),
    .cursor_en_i   (cursor_en),
    .cursor_col_i  (cursor_col),
    .cursor_row_i  (cursor_row),
    .mem           (bus),
    .vga_r_o       (vga_r),
    .vga_g_o       (vga_g),
    .vga_b_o       (vga_b),
    .vga_hs_o      (vga_hs),
    .vga_vs_o      (vga_vs),
    .frame_start_o (frame_start)
  );

  always #5 clk = ~clk;

  // Parent-side memories with one-cycle read latency.
  logic [7:0] map_code_mem [16];
  logic [7:0] map_attr_mem [16];
  logic [7:0] glyph_mem    [1024];

  always @(posedge clk) begin
    bus.map_code  <= map_code_mem[bus.map_addr];
    bus.map_attr  <= map_attr_mem[bus.map_addr];
    bus.glyph_row <= glyph_mem[bus.glyph_addr];
  end

  logic [11:0] pal [16];
  int checks = 0;
  int failures = 0;
  int scroll_m = 0;
  logic [14:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected output vector {fs, hs, vs, r, g, b} for the pixel the counters
  // hold in cycle k after reset release, plus the expected map address.
  task automatic model(input int k, output logic [14:0] e, output bit ca, output int ea);
    int p, h, v, f, col, px, srow, line, mrow, addr, fg, bg, tmp;
    bit first, active, text, hs_m, vs_m, fs_m, swap;
    logic [7:0] code, attr, gl;
    logic [11:0] rgb;
    p = k / CLK_DIV;
    first = (k % CLK_DIV) == 0;
    h = p % H_TOT;
    v = (p / H_TOT) % V_TOT;
    f = p / (H_TOT * V_TOT);
    fs_m = first && h == 0 && v == 0;
    if (fs_m) scroll_m = (int'(scroll_row) >= ROWS) ? 0 : int'(scroll_row);
    active = h < H_ACTIVE && v < V_ACTIVE;
    text = h < COLS * GLYPH_W && v < ROWS * GLYPH_H;
    hs_m = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    vs_m = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    rgb = 12'h000;
    ca = 1'b0;
    ea = 0;
    if (active && text) begin
      col = h / GLYPH_W;
      px = h % GLYPH_W;
      srow = v / GLYPH_H;
      line = v % GLYPH_H;
      mrow = (srow + scroll_m) % ROWS;
      addr = mrow * COLS + col;
      code = map_code_mem[addr];
      attr = map_attr_mem[addr];
      gl = glyph_mem[int'(code) * GLYPH_H + line];
      fg = int'(attr[7:4]);
      bg = int'(attr[3:0]);
      swap = CURSOR_ON && cursor_en && ((f / BLINK_FRAMES) % 2 == 1)
             && col == int'(cursor_col) && srow == int'(cursor_row);
      if (swap) begin
        tmp = fg;
        fg = bg;
        bg = tmp;
      end
      rgb = pal[gl[px] ? fg : bg];
      ca = first;
      ea = addr;
    end
    e = {fs_m, hs_m, vs_m, rgb};
  endtask

  // Input changes keyed to the cycle count of the first run.
  task automatic apply_stim(input int k);
    if (k == FRAME_CYC - 10)            scroll_row = 2;  // frame 1: wrap case
    if (k == FRAME_CYC + FRAME_CYC / 2) scroll_row = 1;  // mid-frame, frame 2 only
    if (k == 3 * FRAME_CYC - 6)         scroll_row = 0;
    if (k == 3 * FRAME_CYC - 4)         cursor_col = 6;  // out of range in frame 3
    if (k == 4 * FRAME_CYC - 4)         cursor_col = 3;
    if (k == 5 * FRAME_CYC - 4)         cursor_en = 1'b0;
  endtask

  task automatic run(input int ncyc, input bit stim);
    logic [14:0] e;
    bit ca;
    int ea;
    for (int k = 0; k < ncyc; k++) begin
      if (stim) apply_stim(k);
      #1;
      model(k, e, ca, ea);
      if (ca) check($sformatf("map_addr k=%0d", k), 32'(bus.map_addr), 32'(ea));
      if (stim && k == 3)
        check("pixel00_white", {20'h0, vga_r, vga_g, vga_b}, 32'hFFF);
      if (stim && k == 3 + CLK_DIV)
        check("pixel10_black", {20'h0, vga_r, vga_g, vga_b}, 32'h000);
      if (stim && k == FRAME_CYC)
        check("scroll_row0_addr", 32'(bus.map_addr), 32'(2 * COLS));
      if (stim && k == FRAME_CYC + GLYPH_H * LINE_CYC)
        check("scroll_row1_wrap_addr", 32'(bus.map_addr), 32'(0));
      exp_q.push_back(e);
      check($sformatf("pix k=%0d", k),
            {17'h0, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b},
            {17'h0, exp_q.pop_front()});
      @(negedge clk);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out"}, {17'h0, frame_start, vga_hs, vga_vs, vga_r, vga_g, vga_b},
          {17'h0, RST_VEC});
    check({tag, "_map_addr"}, 32'(bus.map_addr), 32'(0));
    check({tag, "_glyph_addr"}, 32'(bus.glyph_addr), 32'(0));
  endtask

  task automatic restart_scoreboard();
    exp_q.delete();
    repeat (3) exp_q.push_back(RST_VEC);
    scroll_m = 0;
  endtask

  initial begin
    pal = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
            12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 1024; i++) glyph_mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      logic [3:0] fgr;
      map_code_mem[i] = 8'($urandom);
      fgr = 4'($urandom);
      map_attr_mem[i] = {fgr, fgr ^ 4'($urandom_range(1, 15))};
    end
    map_code_mem[0] = 8'h41;
    map_attr_mem[0] = 8'hF0;
    glyph_mem[8'h41 * GLYPH_H] = 8'h81;

    scroll_row = 3;  // out of range: frame 0 must show map row 0 first
    cursor_en = 1'b1;
    cursor_col = 3;
    cursor_row = 2;

    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    rst_n = 1'b1;
    restart_scoreboard();
    run(6 * FRAME_CYC + 5 * LINE_CYC + 7, 1'b1);

    // Reset in the middle of line 5 of frame 6.
    rst_n = 1'b0;
    #1;
    check_reset("reset_mid_frame");
    repeat (3) @(negedge clk);
    check_reset("reset_mid_hold");
    rst_n = 1'b1;
    restart_scoreboard();
    run(FRAME_CYC + 20, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
